// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, deframes 11-bit frames, queues scan codes in a FIFO.
// Optional frame timeout is enabled by defining PS2_RX_TIMEOUT_EN (default build: partial frames are held indefinitely).
module ps2_rx_fifo #(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          nextdata_n,
  input  logic                          err_clr,
  output logic [7:0]                    data,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0]  r_ps2c_sync;
  logic [2:0]  r_ps2d_sync;
  logic [3:0]  r_bit_cnt;
  logic [8:0]  r_shift;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic w_strobe;
  logic w_bit;
  logic w_frame_end;
  logic w_start_err;
  logic w_stop_err;
  logic w_par_err;
  logic w_push;
  logic w_pop;
  logic w_wr_en;
  logic w_empty;
  logic w_full;
  logic w_ovf_evt;
  logic w_timeout;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ps2c_sync <= 3'b111;
      r_ps2d_sync <= 3'b111;
    end else begin
      r_ps2c_sync <= {r_ps2c_sync[1:0], ps2_clk};
      r_ps2d_sync <= {r_ps2d_sync[1:0], ps2_data};
    end
  end

  // Falling edge of the synchronised clock; data taken from the matching stage of its chain.
  assign w_strobe    = r_ps2c_sync[2] & ~r_ps2c_sync[1];
  assign w_bit       = r_ps2d_sync[1];
  assign w_frame_end = w_strobe && (r_bit_cnt == 4'd10);
  assign w_start_err = w_strobe && (r_bit_cnt == 4'd0) && w_bit;
  assign w_stop_err  = w_frame_end && !w_bit;
  assign w_par_err   = w_frame_end && !(^r_shift);
  assign w_push      = w_frame_end && w_bit && (^r_shift);

`ifdef PS2_RX_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  assign w_timeout = !w_strobe && (r_bit_cnt != 4'd0) && (r_to_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_to_cnt <= 16'd0;
    end else if (w_strobe || (r_bit_cnt == 4'd0) || w_timeout) begin
      r_to_cnt <= 16'd0;
    end else begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Shift register holds data bits then parity (LSB first), so after bit 9 r_shift = {parity, data}.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 9'd0;
    end else if (w_strobe) begin
      case (r_bit_cnt)
        4'd0:    if (!w_bit) r_bit_cnt <= 4'd1;
        4'd10:   r_bit_cnt <= 4'd0;
        default: begin
          r_shift   <= {w_bit, r_shift[8:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      endcase
    end else if (w_timeout) begin
      r_bit_cnt <= 4'd0;
    end
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = !w_empty && !nextdata_n;
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_ovf_evt = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; its contents are never visible while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= r_shift[7:0];
  end

  assign data  = r_mem[r_rd_ptr[AW-1:0]];
  assign ready = !w_empty;
  assign count = r_wr_ptr - r_rd_ptr;

  // NOTE: the set assignments follow the clear, so the last non-blocking write wins and an
  // error arriving together with err_clr leaves its flag set.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (w_ovf_evt) overflow <= 1'b1;
      if (w_par_err) parity_err <= 1'b1;
      if (w_start_err || w_stop_err || w_timeout) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed scenarios plus randomised frames against a queue-based model.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic       err_clr;
  logic [7:0] data;
  logic       ready;
  logic [3:0] count;
  logic       overflow;
  logic       parity_err;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: byte queue plus sticky flags.
  logic [7:0] q[$];
  logic m_ovf, m_par, m_frm;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(16'd100)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .err_clr(err_clr), .data(data), .ready(ready),
    .count(count), .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_status();
    return {q.size() != 0, 4'(q.size()), m_ovf, m_par, m_frm};
  endfunction

  function automatic logic [10:0] build_frame(input logic [7:0] b, input logic par_bad, input logic stop_bad);
    return {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
  endfunction

  // mode 0: plain; 1: one-cycle pop on the final-bit sample cycle; 2: one-cycle err_clr there.
  task automatic send_bits(input logic [10:0] fr, input int first, input int last, input int mode);
    for (int k = first; k <= last; k++) begin
      ps2_data = fr[k];
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      if (k == last && mode != 0) begin
        repeat (2) @(negedge clk);
        if (mode == 1) nextdata_n = 1'b0;
        else           err_clr    = 1'b1;
        @(negedge clk);
        nextdata_n = 1'b1;
        err_clr    = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        repeat (6) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop_bad, input int mode);
    send_bits(build_frame(b, par_bad, stop_bad), 0, 10, mode);
    if (mode == 1 && q.size() != 0) void'(q.pop_front());
    if (mode == 2) begin m_ovf = 0; m_par = 0; m_frm = 0; end
    if (stop_bad) m_frm = 1;
    if (par_bad)  m_par = 1;
    if (!stop_bad && !par_bad) begin
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back(b);
    end
  endtask

  task automatic do_pop(output logic [7:0] d, output logic r);
    r = ready;
    d = data;
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic err_clr_pulse();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovf = 0; m_par = 0; m_frm = 0;
  endtask

  task automatic clear_all();
    logic [7:0] d;
    logic r;
    for (int i = 0; i < 2 * DEPTH && ready; i++) do_pop(d, r);
    q.delete();
    err_clr_pulse();
  endtask

  task automatic test_reset();
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1; err_clr = 1'b0;
    q.delete(); m_ovf = 0; m_par = 0; m_frm = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", {ready, count, overflow, parity_err, frame_err}, 8'h00);
    end
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status()) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", {ready, count, overflow, parity_err, frame_err}, exp_status());
    end
  endtask

  task automatic test_basic();
    logic [7:0] d, e;
    logic r;
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status() || data !== 8'h1C) begin
      n_fail++;
      $display("FAIL basic_fill: status %b data %h expected %b data 1c", {ready, count, overflow, parity_err, frame_err}, data, exp_status());
    end
    for (int i = 0; i < 3; i++) begin
      do_pop(d, r);
      e = q.pop_front();
      n_checks++;
      if (r !== 1'b1 || d !== e) begin
        n_fail++;
        $display("FAIL basic_pop%0d: ready %b data %h expected ready 1 data %h", i, r, d, e);
      end
    end
    n_checks++;
    if ({ready, count} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL basic_empty: ready %b count %0d expected 0 0", ready, count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d, e;
    logic r;
    clear_all();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status() || count !== 4'd8 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full: status %b expected %b", {ready, count, overflow, parity_err, frame_err}, exp_status());
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_pop(d, r);
      e = q.pop_front();
      n_checks++;
      if (r !== 1'b1 || d !== e) begin
        n_fail++;
        $display("FAIL ovf_pop%0d: ready %b data %h expected 1 %h", i, r, d, e);
      end
    end
    do_pop(d, r);
    err_clr_pulse();
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status()) begin
      n_fail++;
      $display("FAIL ovf_clear: status %b expected %b", {ready, count, overflow, parity_err, frame_err}, exp_status());
    end
  endtask

  task automatic test_errors();
    clear_all();
    send_frame(8'h1B, 1, 0, 0);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status()) begin
      n_fail++;
      $display("FAIL bad_parity: status %b expected %b", {ready, count, overflow, parity_err, frame_err}, exp_status());
    end
    send_frame(8'h1B, 0, 1, 0);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status()) begin
      n_fail++;
      $display("FAIL bad_stop: status %b expected %b", {ready, count, overflow, parity_err, frame_err}, exp_status());
    end
    err_clr_pulse();
    // A lone 1 where the start bit belongs is dropped; the following frame still aligns.
    send_bits(11'h7FF, 0, 0, 0);
    m_frm = 1;
    send_frame(8'h3A, 0, 0, 0);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status() || data !== 8'h3A) begin
      n_fail++;
      $display("FAIL bad_start: status %b data %h expected %b data 3a", {ready, count, overflow, parity_err, frame_err}, data, exp_status());
    end
    send_frame(8'h44, 1, 0, 2);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status()) begin
      n_fail++;
      $display("FAIL clr_collision: status %b expected %b", {ready, count, overflow, parity_err, frame_err}, exp_status());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, e;
    logic r;
    clear_all();
    for (int i = 0; i < DEPTH; i++) send_frame(8'hA0 + 8'(i), 0, 0, 0);
    send_frame(8'h55, 0, 0, 1);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status() || count !== 4'd8 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_push_pop: status %b expected %b", {ready, count, overflow, parity_err, frame_err}, exp_status());
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_pop(d, r);
      e = q.pop_front();
      n_checks++;
      if (r !== 1'b1 || d !== e) begin
        n_fail++;
        $display("FAIL simul_drain%0d: ready %b data %h expected 1 %h", i, r, d, e);
      end
    end
  endtask

  task automatic test_partial_frame();
    logic [10:0] fr;
    clear_all();
`ifdef PS2_RX_TIMEOUT_EN
    fr = build_frame(8'h77, 0, 0);
    send_bits(fr, 0, 3, 0);
    repeat (150) @(negedge clk);
    m_frm = 1;
    send_frame(8'h1C, 0, 0, 0);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status() || data !== 8'h1C) begin
      n_fail++;
      $display("FAIL timeout: status %b data %h expected %b data 1c", {ready, count, overflow, parity_err, frame_err}, data, exp_status());
    end
`else
    fr = build_frame(8'h2D, 0, 0);
    send_bits(fr, 0, 3, 0);
    repeat (300) @(negedge clk);
    send_bits(fr, 4, 10, 0);
    q.push_back(8'h2D);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status() || data !== 8'h2D) begin
      n_fail++;
      $display("FAIL partial_hold: status %b data %h expected %b data 2d", {ready, count, overflow, parity_err, frame_err}, data, exp_status());
    end
`endif
  endtask

  task automatic test_reset_midframe();
    clear_all();
    send_frame(8'h12, 0, 0, 0);
    send_frame(8'h34, 1, 0, 0);
    send_bits(build_frame(8'h3C, 0, 0), 0, 4, 0);
    clrn = 1'b0;
    #1;
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: status %b expected 00000000", {ready, count, overflow, parity_err, frame_err});
    end
    q.delete(); m_ovf = 0; m_par = 0; m_frm = 0;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    send_frame(8'hAA, 0, 0, 0);
    n_checks++;
    if ({ready, count, overflow, parity_err, frame_err} !== exp_status() || data !== 8'hAA) begin
      n_fail++;
      $display("FAIL reset_recover: status %b data %h expected %b data aa", {ready, count, overflow, parity_err, frame_err}, data, exp_status());
    end
  endtask

  task automatic test_random();
    logic [7:0] b, d, e;
    logic r;
    int kind;
    clear_all();
    for (int it = 0; it < 24; it++) begin
      b = 8'($urandom);
      kind = $urandom_range(0, 9);
      send_frame(b, kind == 0, kind == 1, 0);
      n_checks++;
      if ({ready, count, overflow, parity_err, frame_err} !== exp_status()) begin
        n_fail++;
        $display("FAIL rand_status%0d: status %b expected %b", it, {ready, count, overflow, parity_err, frame_err}, exp_status());
      end
      for (int p = $urandom_range(0, 2); p > 0 && q.size() != 0; p--) begin
        do_pop(d, r);
        e = q.pop_front();
        n_checks++;
        if (r !== 1'b1 || d !== e) begin
          n_fail++;
          $display("FAIL rand_pop%0d: ready %b data %h expected 1 %h", it, r, d, e);
        end
      end
      if (it % 6 == 5) err_clr_pulse();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_errors();
    test_back_to_back();
    test_partial_frame();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
